// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the iterative binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned ADJ_THRESH = 5;
    localparam int unsigned ADJ_ADD    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adj_c
);

    always_comb begin
        adj_c = digit;
        if (digit >= BCD_W'(ADJ_THRESH)) begin
            adj_c = digit + BCD_W'(ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock with start/done handshake.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int unsigned SCR_W = BCD_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned OUT_W = 4 * BCD_W;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               busy_d, done_d;
    logic [SCR_W-1:0]   scr_adj_c;
    logic [SCR_W-1:0]   scr_shift_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit (scr_q[g*BCD_W +: BCD_W]),
            .adj_c (scr_adj_c[g*BCD_W +: BCD_W])
        );
    end

    // Adjusted scratch shifted left, taking the next binary MSB in at the bottom.
    assign scr_shift_c = {scr_adj_c[SCR_W-2:0], bin_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                scr_d = scr_shift_c;
                cnt_d = cnt_q - CNT_W'(1);
                // Last step publishes the finished digits directly, no extra state.
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = OUT_W'(scr_shift_c);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign thousands = out_q[3*BCD_W +: BCD_W];
    assign hundreds  = out_q[2*BCD_W +: BCD_W];
    assign tens      = out_q[1*BCD_W +: BCD_W];
    assign ones      = out_q[0*BCD_W +: BCD_W];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized checks of bin_to_bcd_seq against an arithmetic decimal reference.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] bin;
    logic        busy;
    logic        done;
    logic [3:0]  thousands, hundreds, tens, ones;

    int passed = 0;
    int total  = 0;

    bin_to_bcd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] digits();
        return {thousands, hundreds, tens, ones};
    endfunction

    // Present start for one accepting edge, then drop it.
    task automatic kick(input int v);
        start = 1'b1;
        bin   = 13'(v);
        step();
        start = 1'b0;
    endtask

    // Step until done; returns cycles waited and busy-high samples seen, bounded.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            if (!done && busy) busy_cnt++;
        end
    endtask

    function automatic logic digits_in_range();
        return (thousands <= 4'd9) && (hundreds <= 4'd9) && (tens <= 4'd9) && (ones <= 4'd9);
    endfunction

    initial begin
        int cyc, bc, extra_done, v;
        logic held;
        logic [15:0] prev;
        int corner[10] = '{0, 9, 10, 99, 100, 999, 1000, 4999, 5000, 8190};

        rst = 1'b1; start = 1'b0; bin = '0;
        step(); step();
        check("reset_digits", 32'(digits()), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        rst = 1'b0;
        step();

        // Zero: latency and busy width
        kick(0);
        bc = busy ? 1 : 0;
        wait_done(cyc, v);
        bc += v;
        check("zero_latency", 32'(cyc), 32'(13));
        check("zero_busy_cycles", 32'(bc), 32'(13));
        check("zero_digits", 32'(digits()), 32'(ref_bcd(0)));
        check("zero_busy_in_done", 32'(busy), 32'(0));
        step();
        check("done_one_cycle", 32'(done), 32'(0));

        // Maximum input
        kick(8191);
        wait_done(cyc, bc);
        check("max_latency", 32'(cyc), 32'(13));
        check("max_digits", 32'(digits()), 32'(16'h8191));

        // Back-to-back: second start issued in the done cycle
        step();
        kick(1234);
        wait_done(cyc, bc);
        check("b2b_first", 32'(digits()), 32'(16'h1234));
        prev = digits();
        kick(5);
        held = (digits() == prev);
        cyc = 1;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            if (!done && digits() != prev) held = 1'b0;
        end
        check("b2b_gap", 32'(cyc), 32'(14));
        check("b2b_held", 32'(held), 32'(1));
        check("b2b_second", 32'(digits()), 32'(16'h0005));

        // Start while busy is ignored
        step();
        kick(4095);
        repeat (4) step();
        start = 1'b1; bin = 13'd9;
        step();
        start = 1'b0;
        wait_done(cyc, bc);
        check("busy_ign_latency", 32'(cyc), 32'(8));
        check("busy_ign_digits", 32'(digits()), 32'(16'h4095));
        extra_done = 0;
        repeat (20) begin
            step();
            if (done) extra_done++;
        end
        check("busy_ign_no_second", 32'(extra_done), 32'(0));

        // Reset mid-conversion aborts
        kick(7777);
        wait_done(cyc, bc);
        check("pre_rst_digits", 32'(digits()), 32'(16'h7777));
        step();
        kick(100);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_digits", 32'(digits()), 32'(0));
        extra_done = 0;
        repeat (20) begin
            step();
            if (done) extra_done++;
        end
        check("rst_no_done", 32'(extra_done), 32'(0));

        // Corner values then random values against the decimal reference
        for (int i = 0; i < 10 + 150; i++) begin
            v = (i < 10) ? corner[i] : int'($urandom_range(0, 8191));
            kick(v);
            wait_done(cyc, bc);
            check($sformatf("conv_%0d", v), 32'(digits()), 32'(ref_bcd(v)));
            check("digit_range", 32'(digits_in_range()), 32'(1));
            step();
        end

        // Start held high: continuous reconversion every 14 cycles
        start = 1'b1; bin = 13'd2024;
        step();
        wait_done(cyc, bc);
        check("hold_first", 32'(digits()), 32'(16'h2024));
        bin = 13'd6543;
        step();
        wait_done(cyc, bc);
        check("hold_period", 32'(cyc + 1), 32'(14));
        check("hold_second", 32'(digits()), 32'(16'h6543));
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
